// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - operand/result handshake bundle for the sequential ALU
interface seq_alu_if #(
  parameter int WIDTH = 19
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             carry;
  logic             div_by_zero;

  // Issue-stage side: presents operations, consumes results
  modport master (
    output in_valid, a, b, alu_op, out_ready,
    input  in_ready, out_valid, result, result_hi, zero, carry, div_by_zero
  );

  // ALU side
  modport slave (
    input  in_valid, a, b, alu_op, out_ready,
    output in_ready, out_valid, result, result_hi, zero, carry, div_by_zero
  );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked multi-cycle ALU with iterative multiply and divide
module seq_alu #(
  parameter int WIDTH = 19
) (
  input logic     clk,
  input logic     rst,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor
  logic [WIDTH-1:0] hi_q, hi_d;       // partial product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;       // multiplier bits / dividend shifting into quotient
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             is_long;
  logic             last_iter;

  logic [WIDTH-1:0] quick_res;
  logic             quick_carry;
  logic             quick_dbz;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;
  logic             div_borrow;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign accept    = bus.in_valid && bus.in_ready;
  assign is_long   = (bus.alu_op == OP_MUL) || ((bus.alu_op == OP_DIV) && (bus.b != '0));
  assign last_iter = (cnt_q == CW'(1));

  // State register plus all datapath flops, cleared together on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      dbz_q    <= dbz_d;
    end
  end

  // Next-state: long ops iterate in BUSY, everything else goes straight to DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = is_long ? S_BUSY : S_DONE;
      S_BUSY:  if (last_iter) state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs and registered result drive-out
  always_comb begin
    bus.in_ready    = (state_q == S_IDLE) && !rst;
    bus.out_valid   = (state_q == S_DONE);
    bus.result      = res_q;
    bus.result_hi   = res_hi_q;
    bus.zero        = zero_q;
    bus.carry       = carry_q;
    bus.div_by_zero = dbz_q;
  end

  // Single-cycle results computed straight from the operands being accepted
  always_comb begin
    quick_res   = '0;
    quick_carry = 1'b0;
    quick_dbz   = 1'b0;
    case (bus.alu_op)
      OP_ADD:  {quick_carry, quick_res} = {1'b0, bus.a} + {1'b0, bus.b};
      OP_SUB: begin
        quick_res   = bus.a - bus.b;
        quick_carry = (bus.a < bus.b);
      end
      OP_DIV:  quick_dbz = (bus.b == '0);
      OP_AND:  quick_res = bus.a & bus.b;
      OP_OR:   quick_res = bus.a | bus.b;
      OP_XOR:  quick_res = bus.a ^ bus.b;
      OP_NOT:  quick_res = ~bus.a;
      default: quick_res = '0;
    endcase
  end

  // One shift-add or one restoring-divide step per BUSY cycle
  always_comb begin
    mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift  = {hi_q, lo_q[WIDTH-1]};
    // One extra bit so the sign of the trial subtraction is the borrow
    div_trial  = {1'b0, div_shift} - {2'b00, opnd_q};
    div_borrow = div_trial[WIDTH+1];
    if (op_q == OP_MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi = div_borrow ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ~div_borrow};
    end
  end

  // Datapath register updates: latch at accept, iterate in BUSY, hold in DONE
  always_comb begin
    op_d     = op_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d     = bus.alu_op;
          opnd_d   = bus.b;
          cnt_d    = CW'(WIDTH);
          hi_d     = '0;
          lo_d     = bus.a;
          res_d    = quick_res;
          res_hi_d = '0;
          zero_d   = (quick_res == '0);
          carry_d  = quick_carry;
          dbz_d    = quick_dbz;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        hi_d  = step_hi;
        lo_d  = step_lo;
        if (last_iter) begin
          res_d    = step_lo;
          res_hi_d = step_hi;
          zero_d   = (step_lo == '0);
          carry_d  = (op_q == OP_MUL) && (step_hi != '0);
          dbz_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu
module tb_seq_alu;
  localparam int W = 19;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present an op at a negedge, let it be accepted, then withdraw in_valid
  task automatic issue(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    bus.alu_op   = op;
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    chk("accept_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Wait for out_valid with a bound; returns cycles since accept
  task automatic wait_done(output int n, output int ready_seen);
    n = 1;
    ready_seen = 0;
    while (!bus.out_valid && n < 100) begin
      if (bus.in_ready) ready_seen++;
      tick();
      n++;
    end
  endtask

  // In DONE with out_ready high: in_ready low now, high one cycle later
  task automatic retire(input string tag);
    chk({tag, "_done_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    tick();
    chk({tag, "_idle_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_idle_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int n;
    int rdy;
    int seen;
    errors       = 0;
    checks       = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a        = '0;
    bus.b        = '0;
    bus.alu_op   = 3'b000;
    @(negedge clk);
    tick();

    // Reset state
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_result_hi", 32'(bus.result_hi), 32'd0);
    chk("rst_flags", {29'd0, bus.zero, bus.carry, bus.div_by_zero}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);

    // ADD wraps to zero with carry
    issue(3'b000, 19'h7FFFF, 19'h00001);
    chk("add_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("add_result", 32'(bus.result), 32'h0);
    chk("add_hi", 32'(bus.result_hi), 32'h0);
    chk("add_flags", {29'd0, bus.zero, bus.carry, bus.div_by_zero}, 32'b110);
    retire("add");

    // SUB borrows
    issue(3'b001, 19'd3, 19'd5);
    chk("sub_result", 32'(bus.result), 32'h7FFFE);
    chk("sub_flags", {29'd0, bus.zero, bus.carry, bus.div_by_zero}, 32'b010);
    retire("sub");

    // NOT ignores b
    issue(3'b111, 19'd0, 19'h12345);
    chk("not_result", 32'(bus.result), 32'h7FFFF);
    chk("not_flags", {29'd0, bus.zero, bus.carry, bus.div_by_zero}, 32'b000);
    retire("not");

    // AND / OR
    issue(3'b100, 19'h0F0F0, 19'h00FF0);
    chk("and_result", 32'(bus.result), 32'h000F0);
    retire("and");
    issue(3'b101, 19'h0F0F0, 19'h00FF0);
    chk("or_result", 32'(bus.result), 32'h0FFF0);
    chk("or_flags", {29'd0, bus.zero, bus.carry, bus.div_by_zero}, 32'b000);
    retire("or");

    // MUL 1000*1000 = 0xF4240
    issue(3'b010, 19'd1000, 19'd1000);
    wait_done(n, rdy);
    chk("mul_latency", 32'(n), 32'd20);
    chk("mul_busy_in_ready", 32'(rdy), 32'd0);
    chk("mul_result", 32'(bus.result), 32'h74240);
    chk("mul_hi", 32'(bus.result_hi), 32'h00001);
    chk("mul_flags", {29'd0, bus.zero, bus.carry, bus.div_by_zero}, 32'b010);
    retire("mul");

    // DIV 100/7 = 14 r 2
    issue(3'b011, 19'd100, 19'd7);
    wait_done(n, rdy);
    chk("div_latency", 32'(n), 32'd20);
    chk("div_result", 32'(bus.result), 32'd14);
    chk("div_hi", 32'(bus.result_hi), 32'd2);
    chk("div_flags", {29'd0, bus.zero, bus.carry, bus.div_by_zero}, 32'b000);
    retire("div");

    // DIV by zero takes the single-cycle path
    issue(3'b011, 19'd5, 19'd0);
    chk("dbz_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("dbz_result", 32'(bus.result), 32'd0);
    chk("dbz_hi", 32'(bus.result_hi), 32'd0);
    chk("dbz_flags", {29'd0, bus.zero, bus.carry, bus.div_by_zero}, 32'b101);
    retire("dbz");

    // Backpressure: XOR held for 5 cycles while inputs churn
    bus.out_ready = 1'b0;
    issue(3'b110, 19'h0F0F0, 19'h00FF0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.alu_op   = 3'b000;
      bus.a        = 19'(i * 7 + 1);
      bus.b        = 19'(i * 3 + 2);
      #1;
      chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_result", 32'(bus.result), 32'h0FF00);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_still_result", 32'(bus.result), 32'h0FF00);
    retire("bp");

    // Reset during MUL at BUSY cycle 10
    issue(3'b010, 19'd1000, 19'd1000);
    for (int i = 0; i < 9; i++) tick();
    chk("mid_busy_valid", {31'd0, bus.out_valid}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_result", 32'(bus.result), 32'd0);
    chk("mid_rst_hi", 32'(bus.result_hi), 32'd0);
    chk("mid_rst_flags", {29'd0, bus.zero, bus.carry, bus.div_by_zero}, 32'b000);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    chk("abandoned_never_valid", 32'(seen), 32'd0);

    // ADD after abandoned op
    issue(3'b000, 19'd2, 19'd2);
    chk("post_add_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("post_add_result", 32'(bus.result), 32'd4);
    chk("post_add_flags", {29'd0, bus.zero, bus.carry, bus.div_by_zero}, 32'b000);
    retire("post_add");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
